// File: rtl/ccff_bitstream_loader.sv
// Byte-wide loader for a ccff configuration chain.
// Shifts bytes LSB-first into the chain head and returns tail bits as bytes.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W:0] LEN_X =
    CW1'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [3:0]       bits_left_q, bits_left_d;
  logic [CNT_W-1:0] shifted_q, shifted_d;
  logic [7:0]       rb_acc_q, rb_acc_d;
  logic [2:0]       rb_cnt_q, rb_cnt_d;
  logic [7:0]       rb_data_q, rb_data_d;
  logic             rb_valid_q, rb_valid_d;

  logic             in_load;
  logic             shift;
  logic             accept;
  logic             last_shift;
  logic             rb_flush;
  logic [CNT_W:0]   committed;
  logic [7:0]       rb_next;

  // Bits already shifted plus bits still queued in sreg.
  assign committed = CW1'(shifted_q)
                   + CW1'(bits_left_q);

  assign in_load    = (state_q == LOAD);
  assign byte_ready = in_load
                   && (bits_left_q <= 4'd1)
                   && (committed < LEN_X);
  assign accept     = byte_valid && byte_ready;
  assign shift      = in_load
                   && (bits_left_q != 4'd0);
  assign last_shift = shift
                   && (shifted_q == LAST);

  assign rb_next  = rb_acc_q
                  | (8'(ccff_tail) << rb_cnt_q);
  assign rb_flush = shift
                 && ((rb_cnt_q == 3'd7)
                 || last_shift);

  assign ccff_shift_en = shift;
  assign ccff_head     = shift & sreg_q[0];
  assign busy          = in_load;
  assign done          = (state_q == DONE);
  assign rb_data       = rb_data_q;
  assign rb_valid      = rb_valid_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bits_left_d = bits_left_q;
    shifted_d   = shifted_q;
    rb_acc_d    = rb_acc_q;
    rb_cnt_d    = rb_cnt_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          sreg_d      = '0;
          bits_left_d = '0;
          shifted_d   = '0;
          rb_acc_d    = '0;
          rb_cnt_d    = '0;
        end
      end
      LOAD: begin
        if (shift) begin
          sreg_d      = sreg_q >> 1;
          bits_left_d = bits_left_q - 4'd1;
          shifted_d   = shifted_q
                      + CNT_W'(1);
          rb_acc_d    = rb_next;
          rb_cnt_d    = rb_cnt_q + 3'd1;
          if (rb_flush) begin
            rb_data_d  = rb_next;
            rb_valid_d = 1'b1;
            rb_acc_d   = '0;
            rb_cnt_d   = '0;
          end
        end
        // A refill may land on the edge of the last queued bit.
        if (accept) begin
          sreg_d      = byte_data;
          bits_left_d = 4'd8;
        end
        if (last_shift) begin
          bits_left_d = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bits_left_q <= '0;
      shifted_q   <= '0;
      rb_acc_q    <= '0;
      rb_cnt_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
      shifted_q   <= shifted_d;
      rb_acc_q    <= rb_acc_d;
      rb_cnt_q    <= rb_cnt_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

endmodule
